pipe_ifu: RTL

Instruction-fetch stage of the in-order pipeline. Holds the architectural fetch PC, issues one word-aligned fetch per instruction over a valid/ready instruction-memory request channel, and captures the response. It presents `{pc, inst}` to the decode stage through a valid/ready handshake and redirects to a new PC on pipeline flush, discarding any fetch still in flight. At most one memory request is outstanding.

---
 rtl/liang_pkg.sv | 18 +
 rtl/pipe_ifu.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/liang_pkg.sv
// liang_pkg: types shared between the front-end pipeline stages.
//   ifToId_t    : fetch -> decode payload {pc, inst}
//   ifu_state_e : instruction-fetch unit control states (2-bit)
package liang_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifToId_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request out to instruction memory
    WAIT  = 2'd1,  // request accepted, waiting for the response
    HOLD  = 2'd2,  // instruction held for decode
    DROP  = 2'd3   // a flushed fetch is still outstanding
  } ifu_state_e;

endpackage

// File: rtl/pipe_ifu.sv
// pipe_ifu: instruction-fetch stage of the in-order pipeline.
//   Holds the fetch PC, issues one word fetch at a time over a valid/ready
//   memory request channel, captures the response and hands {pc, inst} to
//   decode over valid/ready. A flush redirects the PC and discards any fetch
//   still in flight (at most one request is ever outstanding).
//
// Parameters:
//   RESET_PC            first PC fetched after reset
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             redirect request from execute
//   redirect_pc_i       new fetch PC, sampled when flush_i=1
//   imem_req_valid_o    fetch request valid
//   imem_req_ready_i    memory accepts the request
//   imem_req_addr_o     fetch address (= pc)
//   imem_rsp_valid_i    response valid (always accepted)
//   imem_rsp_data_i     fetched instruction word
//   if_valid_o          ifToId_o valid toward decode
//   id_ready_i          decode accepts
//   ifToId_o            {pc, inst} of the held instruction
// Optional feature (macro PIPE_IFU_PERF_EN):
//   perf_fetch_cnt_o    handshakes with decode (flush cycles excluded)
//   perf_stall_cnt_o    cycles spent in WAIT or DROP
module pipe_ifu
  import liang_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        if_valid_o,
  input  logic        id_ready_i,
  output ifToId_t     ifToId_o
`ifdef PIPE_IFU_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt_o,
  output logic [63:0] perf_stall_cnt_o
`endif
);

  ifu_state_e  state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        req_fire_s;

  // Request fire is only possible in FETCH; reset is handled by the FSM itself.
  assign req_fire_s = (state_q == FETCH) && imem_req_ready_i;

  // Output decode: pure function of state, forced quiet while reset is held.
  always_comb begin
    imem_req_addr_o = pc_q;
    if (rst_i) begin
      imem_req_valid_o = 1'b0;
      if_valid_o       = 1'b0;
      ifToId_o         = '0;
    end else begin
      imem_req_valid_o = (state_q == FETCH);
      if_valid_o       = (state_q == HOLD);
      ifToId_o.pc      = pc_q;
      ifToId_o.inst    = inst_q;
    end
  end

  // Fetch FSM. A flush wins over every transition and always loads the
  // redirect PC; the state then only records whether a stale response is
  // still owed by memory (DROP) or not (FETCH).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0000;
    end else if (flush_i) begin
      pc_q <= redirect_pc_i;
      case (state_q)
        FETCH:   state_q <= req_fire_s ? DROP : FETCH;
        WAIT:    state_q <= imem_rsp_valid_i ? FETCH : DROP;
        DROP:    state_q <= imem_rsp_valid_i ? FETCH : DROP;
        HOLD:    state_q <= FETCH;  // decode drops its copy in this cycle too
        default: state_q <= FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (req_fire_s) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid_i) begin
            inst_q  <= imem_rsp_data_i;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (id_ready_i) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= FETCH;
          end
        end
        DROP: begin
          if (imem_rsp_valid_i) begin
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

`ifdef PIPE_IFU_PERF_EN
  logic hs_s;
  logic stall_s;

  // A handshake in a flush cycle is void, so it is not counted.
  assign hs_s    = (state_q == HOLD) && id_ready_i && !flush_i;
  assign stall_s = (state_q == WAIT) || (state_q == DROP);

  // Free-running 64-bit performance counters (wrap naturally).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetch_cnt_o <= 64'd0;
      perf_stall_cnt_o <= 64'd0;
    end else begin
      if (hs_s) begin
        perf_fetch_cnt_o <= perf_fetch_cnt_o + 64'd1;
      end
      if (stall_s) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 64'd1;
      end
    end
  end
`endif

endmodule
